// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// iteration count and a conditional two's-complement helper.
`default_nettype none

package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  localparam int STEPS = 32;
  localparam int CNT_W = 5;

  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// One iteration over the 64-bit accumulator: shift-add for multiply,
// restoring shift-subtract for divide.
`default_nettype none

module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                is_div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     operand_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_new;
  logic            ge;

  always_comb begin
    // Multiply: {HI,LO} holds partial product on top and remaining multiplier bits below.
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    ge      = (rem_sh >= {1'b0, operand_i});
    rem_new = rem_sh[XLEN-1:0] - operand_i;
    if (!is_div_i) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else if (ge) begin
      acc_o = {rem_new, acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller with architectural HI/LO registers,
// 33-cycle latency and pipeline stall generation.
`default_nettype none

module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  input  logic            mf_req,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*XLEN-1:0]     acc_q;
  logic [2*XLEN-1:0]     acc_d;
  logic [XLEN-1:0]       operand_q;
  logic                  is_div_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic                  div0_q;
  logic [XLEN-1:0]       hi_q;
  logic [XLEN-1:0]       lo_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  op_signed;
  logic                  sign_a;
  logic                  sign_b;
  logic [XLEN-1:0]       mag_a;
  logic [XLEN-1:0]       mag_b;
  logic [2*XLEN-1:0]     prod_fix;

  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    sign_a    = op_signed & opA[XLEN-1];
    sign_b    = op_signed & opB[XLEN-1];
    mag_a     = cond_neg32(sign_a, opA);
    mag_b     = cond_neg32(sign_b, opB);
    prod_fix  = neg_quo_q ? (~acc_q + 64'd1) : acc_q;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i  (is_div_q),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .acc_o     (acc_d)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            is_div_q  <= op[1];
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            div0_q    <= (opB == '0);
            // Divide keeps the dividend in LO; multiply keeps the multiplier there.
            acc_q     <= op[1] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            operand_q <= op[1] ? mag_b : mag_a;
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STEPS - 1)) state_q <= S_FINISH;
        end
        S_FINISH: begin
          if (is_div_q) begin
            lo_q <= div0_q ? '1 : cond_neg32(neg_quo_q, acc_q[XLEN-1:0]);
            hi_q <= cond_neg32(neg_rem_q, acc_q[2*XLEN-1:XLEN]);
          end else begin
            hi_q <= prod_fix[2*XLEN-1:XLEN];
            lo_q <= prod_fix[XLEN-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (mf_req | start | mthi | mtlo);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases, randomized
// operations against an arithmetic reference model, hazards and reset abort.
`default_nettype none

module tb_muldiv_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        mf_req = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  muldiv_ctrl #(.XLEN(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .op     (op),
    .opA    (opA),
    .opB    (opB),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .mf_req (mf_req),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
    int          sa;
    int          sb;
    int          sq;
    int          sr;
    longint      p;
    logic [63:0] up;
    sa = int'(a);
    sb = int'(b);
    h = '0;
    l = '0;
    case (o)
      2'd0: begin
        p = longint'(sa) * longint'(sb);
        {h, l} = p;
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        {h, l} = up;
      end
      2'd2: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          l = 32'(sq); h = 32'(sr);
        end
      end
      default: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or after the bound).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l,
                       output int busy_cnt, output int done_at);
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge CLK);
    start = 1'b0;
    busy_cnt = 0;
    done_at  = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
      @(negedge CLK);
    end
    h = hi;
    l = lo;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({hi, lo, busy, done, stall} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state hi=%h lo=%h busy=%b done=%b stall=%b required all zero",
               hi, lo, busy, done, stall);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  vop [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    logic [31:0] va  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] vb  [6] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFF9};
    logic [31:0] el  [6] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] h, l;
    int bc, da;
    for (int i = 0; i < 6; i++) begin
      do_op(vop[i], va[i], vb[i], h, l, bc, da);
      checks++;
      if (h !== eh[i] || l !== el[i]) begin
        errors++;
        $display("FAIL directed_%0d hi=%h lo=%h required hi=%h lo=%h", i, h, l, eh[i], el[i]);
      end
      checks++;
      if (bc != 33 || da != 34) begin
        errors++;
        $display("FAIL latency_%0d busy_cycles=%0d done_at=%0d required 33 and 34", i, bc, da);
      end
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b required 0 one cycle later", done);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] h, l, eh, el, a, b;
    logic [1:0]  o;
    int bc, da;
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      ref_model(o, a, b, eh, el);
      do_op(o, a, b, h, l, bc, da);
      checks++;
      if (h !== eh || l !== el || da != 34) begin
        errors++;
        bad++;
        $display("FAIL random op=%0d a=%h b=%h hi=%h lo=%h done_at=%0d required hi=%h lo=%h done_at=34",
                 o, a, b, h, l, da, eh, el);
      end
    end
  endtask

  task automatic test_busy_hazards();
    logic [31:0] old_hi;
    int done_at = 0;
    old_hi = hi;
    start = 1'b1; op = 2'd1; opA = 32'd3; opB = 32'd4;
    mthi = 1'b1; wdata = ~old_hi;
    @(negedge CLK);
    start = 1'b0; mthi = 1'b0;
    checks++;
    if (hi !== old_hi || busy !== 1'b1) begin
      errors++;
      $display("FAIL mthi_with_start hi=%h busy=%b required hi=%h busy=1", hi, busy, old_hi);
    end
    repeat (4) @(negedge CLK);
    mf_req = 1'b1; start = 1'b1; op = 2'd3; opA = 32'd100; opB = 32'd7;
    mthi = 1'b1; wdata = 32'h1234;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_busy stall=%b required 1", stall);
    end
    @(negedge CLK);
    mf_req = 1'b0; start = 1'b0; mthi = 1'b0;
    for (int n = 6; n <= 45; n++) begin
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
      @(negedge CLK);
    end
    checks++;
    if (done_at != 34 || hi !== 32'd0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL busy_ignore done_at=%0d hi=%h lo=%h required 34 hi=0 lo=c", done_at, hi, lo);
    end
    mf_req = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle stall=%b required 0", stall);
    end
    mf_req = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_lo;
    old_lo = lo;
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge CLK);
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== old_lo) begin
      errors++;
      $display("FAIL mthi_idle hi=%h lo=%h required hi=1234 lo=%h", hi, lo, old_lo);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge CLK);
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL mthi_mtlo_both hi=%h lo=%h required cafef00d both", hi, lo);
    end
  endtask

  task automatic test_abort();
    logic [31:0] h, l;
    int bc, da;
    int saw_done = 0;
    start = 1'b1; op = 2'd0; opA = 32'hFFFF_FFFD; opB = 32'd5;
    @(negedge CLK);
    start = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
    end
    repeat (3) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) saw_done++;
    end
    checks++;
    if (saw_done != 0) begin
      errors++;
      $display("FAIL abort_hold active_cycles=%0d required 0", saw_done);
    end
    RST = 1'b1;
    do_op(2'd3, 32'd1000, 32'd7, h, l, bc, da);
    checks++;
    if (h !== 32'd6 || l !== 32'd142 || da != 34) begin
      errors++;
      $display("FAIL start_after_reset hi=%h lo=%h done_at=%0d required hi=6 lo=8e done_at=34", h, l, da);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_back_to_back();
    test_busy_hazards();
    test_mthi_mtlo();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
